// File: rtl/debug_dump_receiver.sv
// Debug dump receiver: sends a single-step command over UART, then assembles the
// returned byte stream (MSB first) into PC / register / ALU / memory words.
module debug_dump_receiver #(
  parameter int NB               = 32,
  parameter int DATA_BITS        = 8,
  parameter int NUMBER_REGISTERS = 32,
  parameter int NUMBER_MEM_WORDS = 16,
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int TOTAL_WORDS      = 1 + NUMBER_REGISTERS + 1 + NUMBER_MEM_WORDS,
  parameter int NB_IDX           = $clog2(TOTAL_WORDS),
  parameter int NB_STATE         = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_uart_tx_ready,
  input  logic                 i_uart_tx_done,
  input  logic                 i_uart_rx_ready,
  input  logic [DATA_BITS-1:0] i_uart_rx_data,
  output logic [NB-1:0]        o_word,
  output logic [NB_IDX-1:0]    o_word_index,
  output logic [1:0]           o_word_kind,
  output logic                 o_word_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [NB_STATE-1:0]  o_state_debug
);

  localparam int BYTES_PER_WORD = NB / DATA_BITS;
  localparam int NB_BYTE_CNT    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int NB_TO          = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE    = NB_BYTE_CNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_TO-1:0]       TO_LIMIT     = NB_TO'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_IDX-1:0]      LAST_IDX     = NB_IDX'(TOTAL_WORDS - 1);
  localparam logic [NB_IDX-1:0]      REG_LAST_IDX = NB_IDX'(NUMBER_REGISTERS);
  localparam logic [NB_IDX-1:0]      ALU_IDX      = NB_IDX'(NUMBER_REGISTERS + 1);
  localparam logic [DATA_BITS-1:0]   CMD_STEP     = DATA_BITS'(8'h73);

  typedef enum logic [NB_STATE-1:0] {
    IDLE     = NB_STATE'(1),
    SEND_CMD = NB_STATE'(2),
    WAIT_TX  = NB_STATE'(3),
    RECV     = NB_STATE'(4),
    EMIT     = NB_STATE'(5),
    DONE     = NB_STATE'(6)
  } state_t;

  state_t                  state_reg;
  logic [NB_BYTE_CNT-1:0]  byte_cnt_reg;
  logic [NB_IDX-1:0]       word_idx_reg;
  logic [NB_TO-1:0]        timeout_cnt_reg;
  // Only the lower bytes of the word under assembly need storing; the newest
  // byte comes straight from the receiver when the word completes.
  logic [NB-DATA_BITS-1:0] partial_reg;
  logic [NB-1:0]           shift_next;

  assign shift_next    = {partial_reg, i_uart_rx_data};
  assign o_busy        = (state_reg != IDLE);
  assign o_state_debug = state_reg;

  function automatic logic [1:0] kind_of(input logic [NB_IDX-1:0] idx);
    if (idx == '0)               return 2'd0;
    else if (idx <= REG_LAST_IDX) return 2'd1;
    else if (idx == ALU_IDX)      return 2'd2;
    else                          return 2'd3;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= '0;
      word_idx_reg    <= '0;
      timeout_cnt_reg <= '0;
      partial_reg     <= '0;
      o_uart_tx_data  <= '0;
      o_uart_tx_ready <= 1'b0;
      o_word          <= '0;
      o_word_index    <= '0;
      o_word_kind     <= 2'd0;
      o_word_valid    <= 1'b0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            byte_cnt_reg    <= '0;
            word_idx_reg    <= '0;
            timeout_cnt_reg <= '0;
            partial_reg     <= '0;
            state_reg       <= SEND_CMD;
          end
        end
        SEND_CMD: begin
          o_uart_tx_data  <= CMD_STEP;
          o_uart_tx_ready <= 1'b1;
          state_reg       <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_uart_tx_done) begin
            o_uart_tx_ready <= 1'b0;
            o_uart_tx_data  <= '0;
            timeout_cnt_reg <= '0;
            state_reg       <= RECV;
          end
        end
        RECV: begin
          if (i_uart_rx_ready) begin
            partial_reg     <= shift_next[NB-DATA_BITS-1:0];
            timeout_cnt_reg <= '0;
            if (byte_cnt_reg == LAST_BYTE) begin
              byte_cnt_reg <= '0;
              o_word       <= shift_next;
              o_word_index <= word_idx_reg;
              o_word_kind  <= kind_of(word_idx_reg);
              o_word_valid <= 1'b1;
              state_reg    <= EMIT;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end else if (timeout_cnt_reg == TO_LIMIT) begin
            o_error      <= 1'b1;
            byte_cnt_reg <= '0;
            partial_reg  <= '0;
            state_reg    <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
        end
        EMIT: begin
          // A byte landing here is the first byte of the following word.
          if (i_uart_rx_ready) begin
            partial_reg     <= shift_next[NB-DATA_BITS-1:0];
            byte_cnt_reg    <= NB_BYTE_CNT'(1);
            timeout_cnt_reg <= '0;
          end
          if (word_idx_reg == LAST_IDX) begin
            o_done    <= 1'b1;
            state_reg <= DONE;
          end else begin
            word_idx_reg <= word_idx_reg + 1'b1;
            state_reg    <= RECV;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
